// File: rtl/adder_bist_checker.sv
// adder_bist_checker: self-test engine for a combinational W-bit adder.
// Steps {a, b, cin} through every combination, holds each vector for SETTLE
// cycles, samples the adder outputs in a one-cycle CHECK slot, compares them
// against a golden sum, counts mismatches and records the first failing vector.
//
// Handshake: start is a single-cycle request accepted only in IDLE or DONE.
// There is no ready/valid pairing. busy is high from the accepting edge until
// the edge that enters DONE. done (and the pass/err_count/fail_* results it
// qualifies) then holds until the next accepted start or rst.
//
// The FSM state is kept to the listed ports. It can be decoded from busy/done
// (IDLE: both low, SETTLE/CHECK: busy, DONE: done).
module adder_bist_checker #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    output logic             dut_cin,
    input  logic [W-1:0]     dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W+1:0]   err_count,
    output logic             fail_valid,
    output logic [W-1:0]     fail_a,
    output logic [W-1:0]     fail_b,
    output logic             fail_cin,
    output logic [W-1:0]     fail_s,
    output logic             fail_cout
);

    localparam int IW = 2 * W + 1;                    // vector index width
    localparam int EW = 2 * W + 2;                    // error counter width
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IW-1:0] IDX_LAST = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [EW-1:0] err_q, err_d;
    logic          fv_q, fv_d;
    logic [W-1:0]  fa_q, fa_d;
    logic [W-1:0]  fb_q, fb_d;
    logic          fc_q, fc_d;
    logic [W-1:0]  fs_q, fs_d;
    logic          fco_q, fco_d;

    logic [W:0]    golden;
    logic [W:0]    observed;
    logic          mismatch;
    logic [EW-1:0] err_inc;
    logic [EW-1:0] err_new;

    // The index itself is the registered stimulus; cin is the fastest bit.
    assign dut_a      = idx_q[2*W:W+1];
    assign dut_b      = idx_q[W:1];
    assign dut_cin    = idx_q[0];

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_cin   = fc_q;
    assign fail_s     = fs_q;
    assign fail_cout  = fco_q;

    // Golden comparison of the vector currently driven; used only in CHECK.
    always_comb begin
        golden   = {1'b0, dut_a} + {1'b0, dut_b} + {{W{1'b0}}, dut_cin};
        observed = {dut_cout, dut_s};
        mismatch = (golden != observed);
        err_inc  = (&err_q) ? err_q : err_q + 1'b1;
    end

    // Next-state and result update logic; every register holds by default.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fc_d    = fc_q;
        fs_d    = fs_q;
        fco_d   = fco_q;
        err_new = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    fc_d    = 1'b0;
                    fs_d    = '0;
                    fco_d   = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_new = err_inc;
                end
                err_d = err_new;
                // Only the first failure of a sweep is recorded.
                if (mismatch && !fv_q) begin
                    fv_d  = 1'b1;
                    fa_d  = dut_a;
                    fb_d  = dut_b;
                    fc_d  = dut_cin;
                    fs_d  = dut_s;
                    fco_d = dut_cout;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_new == '0);
                end else begin
                    state_d = ST_SETTLE;
                    idx_d   = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything and abandons a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fc_q    <= 1'b0;
            fs_q    <= '0;
            fco_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fc_q    <= fc_d;
            fs_q    <= fs_d;
            fco_q   <= fco_d;
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: a behavioural adder with selectable faults
// sits beside the checker, and a reference model derived from plain integer
// arithmetic predicts every observable output cycle by cycle.
module tb_adder_bist_checker;

  localparam int W      = 4;
  localparam int SETTLE = 1;
  localparam int N      = 1 << (2 * W + 1);
  localparam int SWEEP  = N * (SETTLE + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [W-1:0]   dut_a, dut_b, dut_s;
  logic           dut_cin, dut_cout;
  logic           busy, done, pass, fail_valid, fail_cin, fail_cout;
  logic [2*W+1:0] err_count;
  logic [W-1:0]   fail_a, fail_b, fail_s;

  adder_bist_checker #(.W(W), .SETTLE(SETTLE)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_cin    (dut_cin),
    .dut_s      (dut_s),
    .dut_cout   (dut_cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_cin   (fail_cin),
    .fail_s     (fail_s),
    .fail_cout  (fail_cout)
  );

  // ---------------- adder under test (with fault modes) ----------------
  // mode 0: correct, 1: cout stuck at 0, 2: s[0] inverted, 3: random bit flips
  int         mode;
  logic [W:0] flip_mask [N];

  function automatic int adder_result(int m, int a, int b, int c, int mask);
    int r;
    r = a + b + c;
    case (m)
      1: r = r & ((1 << W) - 1);
      2: r = r ^ 1;
      3: r = r ^ mask;
      default: r = r;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [W:0] r;
    r = (W + 1)'(adder_result(mode, int'(dut_a), int'(dut_b), int'(dut_cin),
                               int'(flip_mask[{dut_a, dut_b, dut_cin}])));
    dut_s    = r[W-1:0];
    dut_cout = r[W];
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [W:0] exp_q[$];   // observed adder result of each failing vector, in order
  int bad_idx_q[$];       // index of each failing vector, in order
  int err_before [N + 1]; // failing vectors among the first k vectors

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: for every vector, does the adder's answer differ from a+b+cin?
  task automatic build_model();
    exp_q.delete();
    bad_idx_q.delete();
    err_before[0] = 0;
    for (int v = 0; v < N; v++) begin
      int a, b, c, truth, got;
      a = v >> (W + 1);
      b = (v >> 1) & ((1 << W) - 1);
      c = v & 1;
      truth = a + b + c;
      got = adder_result(mode, a, b, c, int'(flip_mask[v]));
      if (got != truth) begin
        exp_q.push_back((W + 1)'(got));
        bad_idx_q.push_back(v);
      end
      err_before[v + 1] = bad_idx_q.size();
    end
  endtask

  // Checks every observable output after the c-th edge following the start edge.
  task automatic check_cycle(input int c);
    int nchk, e, vec;
    nchk = (c >= SWEEP) ? N : c / (SETTLE + 1);
    e = err_before[nchk];
    vec = (c >= SWEEP) ? N - 1 : c / (SETTLE + 1);
    chk($sformatf("busy@%0d", c), busy, (c < SWEEP) ? 1 : 0);
    chk($sformatf("done@%0d", c), done, (c >= SWEEP) ? 1 : 0);
    chk($sformatf("pass@%0d", c), pass, (c >= SWEEP && e == 0) ? 1 : 0);
    chk($sformatf("err_count@%0d", c), err_count, e);
    chk($sformatf("fail_valid@%0d", c), fail_valid, (e > 0) ? 1 : 0);
    chk($sformatf("vector@%0d", c), {dut_a, dut_b, dut_cin}, vec);
    if (c % 64 == 0 || c >= SWEEP) begin
      chk($sformatf("fail_vec@%0d", c), {fail_a, fail_b, fail_cin},
          (e > 0) ? bad_idx_q[0] : 0);
      chk($sformatf("fail_obs@%0d", c), {fail_cout, fail_s},
          (e > 0) ? int'(exp_q[0]) : 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Full sweep with extra start pulses seen at edges ex1+1 and ex2+1 (-1: none).
  task automatic run_sweep(input int m, input int ex1, input int ex2);
    mode = m;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= SWEEP; c++) begin
      check_cycle(c);
      start = (c == ex1 || c == ex2) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fvalid"}, fail_valid, 0);
    chk({tag, "_vec"}, {dut_a, dut_b, dut_cin}, 0);
    chk({tag, "_fvec"}, {fail_a, fail_b, fail_cin, fail_cout, fail_s}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r1, r2;
    checks = 0;
    errors = 0;
    mode   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    for (int v = 0; v < N; v++) flip_mask[v] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // Correct adder with extra start pulses mid-sweep.
    run_sweep(0, 10, 500);

    // cout stuck at 0.
    run_sweep(1, -1, -1);
    chk("stuck_cout_err", err_count, 256);
    chk("stuck_cout_first", {fail_a, fail_b, fail_cin, fail_cout, fail_s},
        {4'd0, 4'd15, 1'b1, 1'b0, 4'd0});

    // Restart from DONE with errors using a correct adder.
    run_sweep(0, -1, -1);

    // s[0] inverted.
    run_sweep(2, -1, -1);
    chk("inv_s0_err", err_count, 512);
    chk("inv_s0_first", {fail_a, fail_b, fail_cin, fail_cout, fail_s},
        {4'd0, 4'd0, 1'b0, 1'b0, 4'd1});

    // Random sparse bit flips, random extra start pulses.
    for (int v = 0; v < N; v++)
      flip_mask[v] = ($urandom_range(0, 15) == 0) ? (W + 1)'($urandom_range(1, (1 << (W + 1)) - 1)) : '0;
    flip_mask[$urandom_range(0, N - 1)] = (W + 1)'($urandom_range(1, (1 << (W + 1)) - 1));
    r1 = $urandom_range(1, SWEEP - 2);
    r2 = $urandom_range(1, SWEEP - 2);
    run_sweep(3, r1, r2);

    // Reset in the middle of a sweep.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");

    // rst and start together: reset wins.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check_zero("rst_start");
    @(negedge clk);
    check_zero("rst_start_idle");

    // Fresh sweep after reset.
    run_sweep(0, -1, -1);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bist_checker.md
Name: adder_bist_checker

Overview:
- Self-test engine for a combinational W-bit adder with carry-in/carry-out (default 4-bit, matching cla_4bit).
- Drives every {a, b, cin} combination into the adder under test.
- Samples s/cout after a programmable settle time, compares them against an internal golden sum, counts mismatches and captures the first failing vector.
- Sits beside the adder in the test wrapper: it produces the adder's inputs, consumes its outputs, and reports pass/fail.

Parameters:
- W, 4, operand width of the adder under test (2..8).
- SETTLE, 1, cycles each vector is held before sampling (>=1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a sweep. Honoured only in IDLE or DONE.
- dut_a  output  W  operand a to the adder; registered.
- dut_b  output  W  operand b to the adder; registered.
- dut_cin  output  1  carry-in to the adder; registered.
- dut_s  input  W  sum from the adder.
- dut_cout  input  1  carry-out from the adder.
- busy  output  1  high while a sweep runs.
- done  output  1  high in DONE, held until start or rst.
- pass  output  1  valid when done=1: 1 iff err_count==0. 0 otherwise.
- err_count  output  2W+2  number of mismatching vectors; saturates at all-ones.
- fail_valid  output  1  a first failure has been captured this sweep.
- fail_a, fail_b  output  W each  operands of the first failing vector.
- fail_cin  output  1  carry-in of the first failing vector.
- fail_s  output  W  observed sum of the first failing vector.
- fail_cout  output  1  observed carry-out of the first failing vector.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-sweep: state=IDLE; every output and internal register is 0 (dut_a/b/cin, busy, done, pass, err_count, fail_*). Any sweep in progress is abandoned.
- Vector index idx: 2W+1 bits.
  - dut_a = idx[2W:W+1], dut_b = idx[W:1], dut_cin = idx[0], so cin toggles fastest.
  - Total vectors N = 2^(2W+1); N = 512 for W=4.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> idx=0, dut_* = vector 0, err_count=0, fail_*=0, busy=1, done=0, pass=0 -> SETTLE.
- SETTLE:
  - Hold dut_* for exactly SETTLE cycles (internal count), then go to CHECK.
- CHECK (1 cycle):
  - Golden result = dut_a + dut_b + dut_cin, computed at W+1 bits.
  - Compare golden against {dut_cout, dut_s}.
  - On mismatch: err_count += 1 (saturating). If fail_valid=0, capture fail_a/b/cin from dut_*, fail_s/fail_cout from the observed inputs, and set fail_valid=1. Later mismatches do not overwrite the capture.
  - If idx = N-1: go to DONE; busy=0, done=1, pass = (err_count after this check == 0).
  - Otherwise: idx+1, drive the new vector on dut_* in the same edge, go to SETTLE.
- Throughput: SETTLE+1 cycles per vector. done rises 512*(SETTLE+1) edges after the edge that samples start (1024 for defaults).
- start while busy (SETTLE/CHECK): ignored, no effect.
- DONE: results and dut_* hold their last values. start=1 behaves exactly as in IDLE: results clear and a new sweep begins.
- rst and start asserted together: rst wins.
- dut_s/dut_cout are sampled only in CHECK; their values in other states are don't-care.

Test Plan:
- Correct behavioural adder, start pulse -> busy for 1024 cycles; then done=1, pass=1, err_count=0, fail_valid=0. dut_* stepped through 0..511 in order.
- Adder with dut_cout stuck at 0 -> err_count=256, pass=0, fail_valid=1. First fail: a=0, b=15, cin=1, fail_s=0000, fail_cout=0.
- Adder with s[0] inverted -> err_count=512, pass=0. First fail: a=0, b=0, cin=0, fail_s=0001, fail_cout=0.
- Extra start pulses at cycles 10 and 500 of a running sweep -> no restart; done still arrives at cycle 1024.
- rst asserted at cycle 300 -> next cycle: IDLE, all outputs 0. Fresh start -> full 1024-cycle sweep with correct results.
- From DONE with err_count=256, start again using a correct adder -> err_count and fail_valid cleared on the start edge; final pass=1, err_count=0.
